// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   IMEM_IWIDTH / IMEM_AWIDTH : widths of the response tag fields.
//   INSTR_ALIGN_BITS          : byte-offset bits that must be zero in a fetch address.
//   NOP_INSTR                 : word returned for a faulting fetch (addi x0, x0, 0).
//   imem_tag_t                : {addr, instr, err} carried from accept to response.
//   imem_boot_word()          : power-up program image of the ROM (addi x1, x0, idx+1).
package imem_pkg;

    localparam int IMEM_IWIDTH      = 32;
    localparam int IMEM_AWIDTH      = 32;
    localparam int INSTR_ALIGN_BITS = 2;

    localparam logic [IMEM_IWIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IMEM_AWIDTH-1:0] addr;
        logic [IMEM_IWIDTH-1:0] instr;
        logic                   err;
    } imem_tag_t;

    // Each word loads its own index+1 into x1, so every location is distinct
    // and recognisable on a waveform.
    function automatic logic [IMEM_IWIDTH-1:0] imem_boot_word(input int unsigned idx);
        return {12'(idx + 1), 20'h00093};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
//   c_clk   : clock
//   clr     : synchronous clear (empties the FIFO; dominates push/pop)
//   push    : write wr_data (accepted when not full, or when full and popping)
//   wr_data : data to write
//   pop     : remove head entry (ignored when empty)
//   rd_data : current head entry
//   full    : DEPTH entries held
//   empty   : no entries held
//   count   : number of entries held
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             c_clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge c_clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_mem_resp.sv
// instr_mem_resp: responder side of the instruction-fetch interface.
// A fetch accepted on the request channel returns {addr, instr, err} on the
// response channel LATENCY cycles later (or later if older responses are
// still waiting). Responses return in order; im_i_flush drops everything.
//
// Ports:
//   c_clk, c_rst              : clock, synchronous active-high reset
//   im_i_req_valid/o_req_ready: request handshake, im_i_addr = byte address
//   im_i_flush                : discard all outstanding requests/responses
//   im_o_rsp_valid/i_rsp_ready: response handshake
//   im_o_instr/addr/err       : response payload (all zero when no response)
//   im_i_we/waddr/wdata       : program-load write port, only with the
//                               IMEM_WRITE_PORT_EN macro defined
//
// Without IMEM_WRITE_PORT_EN the ROM holds the fixed image from
// imem_boot_word(); with it, the array is loaded through the write port.
// IWIDTH / AWIDTH_INSTR must equal the tag field widths in imem_pkg.
module instr_mem_resp
    import imem_pkg::*;
#(
    parameter int IWIDTH       = IMEM_IWIDTH,
    parameter int AWIDTH_INSTR = IMEM_AWIDTH,
    parameter int DEPTH        = 36,
    parameter int LATENCY      = 2,
    parameter int QDEPTH       = 4
) (
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    im_i_req_valid,
    output logic                    im_o_req_ready,
    input  logic [AWIDTH_INSTR-1:0] im_i_addr,
    input  logic                    im_i_flush,
`ifdef IMEM_WRITE_PORT_EN
    input  logic                    im_i_we,
    input  logic [AWIDTH_INSTR-1:0] im_i_waddr,
    input  logic [IWIDTH-1:0]       im_i_wdata,
`endif
    output logic                    im_o_rsp_valid,
    input  logic                    im_i_rsp_ready,
    output logic [IWIDTH-1:0]       im_o_instr,
    output logic [AWIDTH_INSTR-1:0] im_o_addr,
    output logic                    im_o_err
);

    localparam int IDXW = AWIDTH_INSTR - INSTR_ALIGN_BITS;
    localparam int RAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(QDEPTH + 1);
    localparam int TAGW = $bits(imem_tag_t);

    localparam logic [IDXW-1:0] DEPTH_IDX  = IDXW'(DEPTH);
    localparam logic [CW-1:0]   QDEPTH_CNT = CW'(QDEPTH);

    function automatic logic addr_bad(input logic [AWIDTH_INSTR-1:0] a);
        return (a[INSTR_ALIGN_BITS-1:0] != '0) ||
               (a[AWIDTH_INSTR-1:INSTR_ALIGN_BITS] >= DEPTH_IDX);
    endfunction

    // ---------------- ROM read (registered into pipeline stage 0) ----------
    logic              req_err;
    logic [RAW-1:0]    rd_idx;
    logic [IWIDTH-1:0] rom_word;

    assign req_err = addr_bad(im_i_addr);
    // Faulting fetches never index the array; their word is replaced by NOP.
    assign rd_idx  = req_err ? '0 : im_i_addr[INSTR_ALIGN_BITS +: RAW];

`ifdef IMEM_WRITE_PORT_EN
    logic [IWIDTH-1:0] mem_q [DEPTH];
    logic              wr_en;

    assign wr_en = im_i_we && !addr_bad(im_i_waddr);

    always_ff @(posedge c_clk) begin
        if (wr_en) begin
            mem_q[im_i_waddr[INSTR_ALIGN_BITS +: RAW]] <= im_i_wdata;
        end
    end

    assign rom_word = mem_q[rd_idx];
`else
    logic [IWIDTH-1:0] rom_image [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom_image[gi] = imem_boot_word(gi);
    end

    assign rom_word = rom_image[rd_idx];
`endif

    // ---------------- handshakes and outstanding count ---------------------
    logic          req_hs, rsp_hs;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counting pipeline + FIFO occupancy here is what keeps the FIFO from
    // ever overflowing, so the FIFO's own full flag is not needed.
    assign im_o_req_ready = !c_rst && !im_i_flush && (cnt_q < QDEPTH_CNT);
    assign req_hs         = im_i_req_valid && im_o_req_ready;
    assign rsp_hs         = im_o_rsp_valid && im_i_rsp_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (im_i_flush) begin
            cnt_d = '0;
        end else if (req_hs && !rsp_hs) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!req_hs && rsp_hs) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // ---------------- latency pipeline --------------------------------------
    imem_tag_t                 new_tag;
    logic      [LATENCY-1:0]   pv_q, pv_d;
    imem_tag_t [LATENCY-1:0]   pt_q, pt_d;

    always_comb begin
        new_tag.addr  = im_i_addr;
        new_tag.instr = req_err ? NOP_INSTR : rom_word;
        new_tag.err   = req_err;
    end

    always_comb begin
        pv_d    = '0;
        pt_d    = pt_q;
        pv_d[0] = req_hs;
        pt_d[0] = new_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
        end
        if (im_i_flush) begin
            pv_d = '0;
        end
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            pv_q  <= '0;
            cnt_q <= '0;
        end else begin
            pv_q  <= pv_d;
            cnt_q <= cnt_d;
        end
        pt_q <= pt_d;
    end

    // ---------------- response FIFO -----------------------------------------
    imem_tag_t     head_tag;
    logic          fifo_empty, fifo_full, fifo_push, fifo_clr;
    logic [CW-1:0] fifo_count;

    assign fifo_push = pv_q[LATENCY-1] && !im_i_flush;
    assign fifo_clr  = c_rst || im_i_flush;

    sync_fifo #(
        .WIDTH (TAGW),
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .c_clk   (c_clk),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .wr_data (pt_q[LATENCY-1]),
        .pop     (rsp_hs),
        .rd_data (head_tag),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = &{1'b0, fifo_full, fifo_count};

    // Payload is forced to zero whenever no response is offered, so stale
    // FIFO storage never leaks out after reset or flush.
    assign im_o_rsp_valid = !fifo_empty;

    always_comb begin
        im_o_instr = '0;
        im_o_addr  = '0;
        im_o_err   = 1'b0;
        if (im_o_rsp_valid) begin
            im_o_instr = head_tag.instr;
            im_o_addr  = head_tag.addr;
            im_o_err   = head_tag.err;
        end
    end

endmodule

// File: tb/tb_instr_mem_resp.sv
// tb_instr_mem_resp: directed and random checking of instr_mem_resp against
// an in-order queue model (entry becomes visible LATENCY cycles after accept).
// Define IMEM_WRITE_PORT_EN to exercise the program-load write port.
module tb_instr_mem_resp;

    localparam int          LAT  = 2;
    localparam int          QD   = 4;
    localparam int          ROMD = 36;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        c_clk, c_rst;
    logic        req_valid, req_ready, flush;
    logic        rsp_valid, rsp_ready, err_o;
    logic [31:0] addr_i, instr_o, addr_o;
`ifdef IMEM_WRITE_PORT_EN
    logic        we;
    logic [31:0] waddr, wdata;
`endif

    instr_mem_resp #(
        .IWIDTH       (32),
        .AWIDTH_INSTR (32),
        .DEPTH        (ROMD),
        .LATENCY      (LAT),
        .QDEPTH       (QD)
    ) dut (
        .c_clk          (c_clk),
        .c_rst          (c_rst),
        .im_i_req_valid (req_valid),
        .im_o_req_ready (req_ready),
        .im_i_addr      (addr_i),
        .im_i_flush     (flush),
`ifdef IMEM_WRITE_PORT_EN
        .im_i_we        (we),
        .im_i_waddr     (waddr),
        .im_i_wdata     (wdata),
`endif
        .im_o_rsp_valid (rsp_valid),
        .im_i_rsp_ready (rsp_ready),
        .im_o_instr     (instr_o),
        .im_o_addr      (addr_o),
        .im_o_err       (err_o)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_rom [ROMD];
    int          n_chk   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          dut_acc = 0;
    int          dut_rsp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void lookup(input logic [31:0] a, output logic [31:0] w, output logic e);
        e = (a[1:0] != 2'b00) || ((a >> 2) >= ROMD);
        w = e ? NOP : model_rom[a >> 2];
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance the model
    // at the rising edge, return 1 time unit after it.
    task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                        input logic fl, input logic rs);
        logic        ev, er, e;
        logic [31:0] w;
        exp_t        ent;
        req_valid = rv;
        addr_i    = a;
        rsp_ready = rr;
        flush     = fl;
        c_rst     = rs;
        @(negedge c_clk);
        ev = (q.size() > 0) && (q[0].t <= cyc);
        er = !rs && !fl && (q.size() < QD);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_instr", instr_o, q[0].instr);
            chk("rsp_addr", addr_o, q[0].addr);
            chk("rsp_err", 32'(err_o), 32'(q[0].err));
        end
        if (rv && req_ready) dut_acc++;
        if (rsp_valid && rr) begin
            dut_rsp++;
            $display("rsp addr=%08h instr=%08h err=%0b", addr_o, instr_o, err_o);
        end
        @(posedge c_clk);
        cyc++;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (ev && rr) void'(q.pop_front());
            if (rv && er) begin
                lookup(a, w, e);
                ent.addr  = a;
                ent.instr = w;
                ent.err   = e;
                ent.t     = cyc + LAT;
                q.push_back(ent);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 1'b0);
    endtask

`ifdef IMEM_WRITE_PORT_EN
    task automatic wstep(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        we    = 1'b0;
        if (a[1:0] == 2'b00 && (a >> 2) < ROMD) model_rom[a >> 2] = d;
    endtask
`endif

    initial begin
        int          base;
        logic [31:0] ra;
        int          sel;

        for (int i = 0; i < ROMD; i++) model_rom[i] = (i + 1) * 32'h0010_0000 + 32'h93;

        c_rst     = 1'b1;
        req_valid = 1'b0;
        addr_i    = 32'h0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
`ifdef IMEM_WRITE_PORT_EN
        we    = 1'b0;
        waddr = 32'h0;
        wdata = 32'h0;
`endif
        repeat (2) @(posedge c_clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_instr", instr_o, 32'h0);

`ifdef IMEM_WRITE_PORT_EN
        for (int i = 0; i < ROMD; i++) wstep(32'(i * 4), model_rom[i]);
`endif

        // Three back-to-back fetches, consumer always ready.
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
        base = dut_rsp;
        idle(5, 1'b1);
        chk("three_rsp_count", 32'(dut_rsp - base), 32'd3);

        // Consumer stalled: only QDEPTH requests may be accepted, head held.
        base = dut_acc;
        for (int i = 0; i < 6; i++) step(1'b1, 32'(32'h10 + i * 4), 1'b0, 1'b0, 1'b0);
        chk("accepts_when_blocked", 32'(dut_acc - base), 32'd4);
        idle(3, 1'b0);
        base = dut_rsp;
        idle(8, 1'b1);
        chk("drained_rsp_count", 32'(dut_rsp - base), 32'd4);

        // Faulting fetches: misaligned and one past the last word.
        step(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h90, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Flush with three requests in flight.
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h28, 1'b0, 1'b0, 1'b0);
        base = dut_rsp;
        step(1'b1, 32'h2C, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("no_rsp_after_flush", 32'(dut_rsp - base), 32'd0);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Reset with two responses queued.
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        idle(2, 1'b1);

        // Random traffic including faults, stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       ra = 32'($urandom_range(0, ROMD - 1) * 4);
            else if (sel == 7) ra = 32'($urandom_range(0, ROMD - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 8) ra = 32'($urandom_range(ROMD, 63) * 4);
            else               ra = $urandom;
            step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end
        idle(8, 1'b1);

`ifdef IMEM_WRITE_PORT_EN
        wstep(32'h10, 32'hDEAD_BEEF);
        wstep(32'h12, 32'h1111_1111);
        wstep(32'h90, 32'h2222_2222);
        step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
